// File: rtl/led_pkg.sv
// ---------------------------------------------------------------------------
// led_pkg
//
// Purpose : Shared constants and helpers for the LED pattern generator.
//           It holds the mode encodings that match the board switch layout,
//           the bounce direction encoding and the LED bus width.
// Contents: LED_W, MODE_* constants, DIR_* constants,
//           start_value() returns the pattern loaded on entry to a mode,
//           is_onehot() reports whether a pattern is a valid bounce state.
// ---------------------------------------------------------------------------
package led_pkg;

    localparam int LED_W = 8;

    localparam logic [1:0] MODE_COUNT  = 2'b00;
    localparam logic [1:0] MODE_BOUNCE = 2'b01;
    localparam logic [1:0] MODE_BLINK  = 2'b10;
    localparam logic [1:0] MODE_MANUAL = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Bounce starts with the lowest LED lit. Every other mode starts dark.
    function automatic logic [LED_W-1:0] start_value(input logic [1:0] m);
        logic [LED_W-1:0] v;
        v = '0;
        if (m == MODE_BOUNCE) begin
            v = 8'h01;
        end
        return v;
    endfunction

    // A bounce pattern is valid only when exactly one LED is lit.
    function automatic logic is_onehot(input logic [LED_W-1:0] v);
        return (v != '0) && ((v & (v - 8'd1)) == '0);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// ---------------------------------------------------------------------------
// tick_prescaler
//
// Purpose : Free-running divider that produces a one-cycle tick every
//           PRESCALE enabled clock cycles. Other pacing logic on the board
//           reuses it as well as the pattern generator.
// Params  : PRESCALE - cycles per tick. The legal range is 2 .. 2^32-1.
// Ports   : clk   in  rising-edge clock
//           rst_n in  asynchronous active-low reset
//           en    in  1 = count, 0 = hold the count and suppress tick
//           clr   in  synchronous restart of the count from zero
//           tick  out high during the cycle where the count is PRESCALE-1
// ---------------------------------------------------------------------------
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [31:0] LAST = 32'(PRESCALE - 1);

    logic [31:0] count;

    // The counter walks 0..PRESCALE-1 and wraps on the edge that follows
    // the terminal count. A clear always restarts it from zero, even while
    // the counter is disabled, so a new mode never inherits a partial period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + 32'd1;
        end
    end

    // The tick is decoded from the held count. Gating it with en keeps a
    // frozen counter that stopped on its terminal value from pulsing.
    assign tick = en && (count == LAST);

endmodule

// File: rtl/led_pattern_gen.sv
// ---------------------------------------------------------------------------
// led_pattern_gen
//
// Purpose : Generates LED patterns for the LEDs_mgmt input bus. The patterns
//           are a binary count, a bouncing single LED, a blink, or a count
//           stepped by a push button. Timed patterns advance once per
//           prescaler tick.
// Params  : PRESCALE   - clk cycles per pattern step
//           DEB_CYCLES - stable cycles needed to accept a step_btn level.
//                        It is used only when the debouncer is built.
// Macro   : PATTERN_GEN_DEBOUNCE_EN - when defined, a debouncer filters the
//           synchronised step_btn before edge detection.
// Ports   : clk         in   system clock, rising edge
//           rst_n       in   asynchronous active-low reset
//           en          in   1 = advance patterns, 0 = freeze
//           mode[1:0]   in   00 count, 01 bounce, 10 blink, 11 manual (async)
//           step_btn    in   raw active-high push button (async)
//           pattern_out out  LED pattern
//           tick_o      out  one-cycle pulse on each prescaler wrap
// ---------------------------------------------------------------------------
module led_pattern_gen
    import led_pkg::*;
#(
    parameter int unsigned PRESCALE   = 50_000_000,
    parameter int unsigned DEB_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    output logic [LED_W-1:0] pattern_out,
    output logic             tick_o
);

    logic [1:0]       mode_s1, mode_s2, mode_q;
    logic             step_s1, step_s2;
    logic             step_level, step_prev, step_rise;
    logic             dir;
    logic             tick;
    logic             mode_change;
    logic [LED_W-1:0] pattern;
    logic [LED_W-1:0] shl, shr;

    // The switch and button inputs come from the board without any timing
    // relationship to clk. Each one passes through two flops before any
    // logic sees it. step_prev keeps the previous conditioned level so that
    // rising edges can be found.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_s1   <= MODE_COUNT;
            mode_s2   <= MODE_COUNT;
            step_s1   <= 1'b0;
            step_s2   <= 1'b0;
            step_prev <= 1'b0;
        end else begin
            mode_s1   <= mode;
            mode_s2   <= mode_s1;
            step_s1   <= step_btn;
            step_s2   <= step_s1;
            step_prev <= step_level;
        end
    end

`ifdef PATTERN_GEN_DEBOUNCE_EN
    localparam logic [31:0] DEB_LAST = 32'(DEB_CYCLES - 1);

    logic [31:0] deb_cnt;

    // The conditioned level follows the synchronised button only after the
    // new level has been seen for DEB_CYCLES cycles in a row. Whenever the
    // input agrees with the current level again, the count starts over, so
    // short bounces never reach the edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt    <= '0;
            step_level <= 1'b0;
        end else if (step_s2 == step_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            deb_cnt    <= '0;
            step_level <= step_s2;
        end else begin
            deb_cnt <= deb_cnt + 32'd1;
        end
    end
`else
    assign step_level = step_s2;
`endif

    assign step_rise   = step_level & ~step_prev;
    assign mode_change = (mode_s2 != mode_q);
    assign shl         = pattern << 1;
    assign shr         = pattern >> 1;

    // The prescaler restarts whenever the mode changes, so the first step
    // in a new mode always comes one full period after the reload.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (mode_change),
        .tick  (tick)
    );

    // Pattern update. A mode change has priority over everything else, and a
    // tick in the same cycle as a mode change is dropped in favour of the
    // reload. Manual mode ignores ticks and moves only on button edges.
    // Each timed mode applies its own rule on a tick. In bounce mode,
    // dir flips on the same edge that reaches an end LED, so each end LED
    // shows for a single step per sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= MODE_COUNT;
            pattern <= '0;
            dir     <= DIR_LEFT;
        end else if (mode_change) begin
            mode_q  <= mode_s2;
            pattern <= start_value(mode_s2);
            dir     <= DIR_LEFT;
        end else if (mode_q == MODE_MANUAL) begin
            if (en && step_rise) begin
                pattern <= pattern + 8'd1;
            end
        end else if (tick) begin
            case (mode_q)
                MODE_COUNT: begin
                    pattern <= pattern + 8'd1;
                end
                MODE_BOUNCE: begin
                    if (!is_onehot(pattern)) begin
                        pattern <= 8'h01;
                        dir     <= DIR_LEFT;
                    end else if (dir == DIR_LEFT) begin
                        pattern <= shl;
                        if (shl == 8'h80) begin
                            dir <= DIR_RIGHT;
                        end
                    end else begin
                        pattern <= shr;
                        if (shr == 8'h01) begin
                            dir <= DIR_LEFT;
                        end
                    end
                end
                MODE_BLINK: begin
                    pattern <= ~pattern;
                end
                default: begin
                    pattern <= pattern;
                end
            endcase
        end
    end

    assign pattern_out = pattern;
    assign tick_o      = tick;

endmodule

// File: tb/tb_led_pattern_gen.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_gen
//
// Purpose : Directed self-checking bench for led_pattern_gen with
//           PRESCALE=4 and DEB_CYCLES=3. Expected outputs go into a
//           scoreboard queue when the stimulus is driven. They are popped and
//           compared at negative clock edges. The glitch response and the
//           button latency follow PATTERN_GEN_DEBOUNCE_EN.
// ---------------------------------------------------------------------------
module tb_led_pattern_gen;
    import led_pkg::*;

    localparam int PRESCALE   = 4;
    localparam int DEB_CYCLES = 3;

`ifdef PATTERN_GEN_DEBOUNCE_EN
    localparam int         STEP_LAT   = 2 + DEB_CYCLES + 1;
    localparam logic [7:0] GLITCH_INC = 8'd0;
`else
    localparam int         STEP_LAT   = 3;
    localparam logic [7:0] GLITCH_INC = 8'd1;
`endif

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       en       = 1'b0;
    logic [1:0] mode     = 2'b00;
    logic       step_btn = 1'b0;
    logic [7:0] pattern_out;
    logic       tick_o;

    typedef struct packed {
        logic       chk_tick;
        logic       tick;
        logic [7:0] pat;
    } exp_t;

    exp_t exp_q[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;

    always #5 clk = ~clk;

    led_pattern_gen #(
        .PRESCALE   (PRESCALE),
        .DEB_CYCLES (DEB_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .mode        (mode),
        .step_btn    (step_btn),
        .pattern_out (pattern_out),
        .tick_o      (tick_o)
    );

    // Drive every DUT input in one step.
    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m, input logic b);
        rst_n    = r;
        en       = e;
        mode     = m;
        step_btn = b;
    endtask

    // Queue one expected observation. chk_tick selects whether tick_o is checked.
    task automatic pushExp(input logic [7:0] p, input logic ct, input logic t);
        exp_q.push_back(exp_t'({ct, t, p}));
    endtask

    // Pop the oldest expectation and compare it with the current outputs.
    task automatic checkOutput(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $error("[TB] FAIL %s: scoreboard empty, observed pattern %h", tag, pattern_out);
        end else begin
            e = exp_q.pop_front();
            n_compared++;
            assert (pattern_out === e.pat) else begin
                n_mismatched++;
                $error("[TB] FAIL %s: pattern observed %h expected %h at %0t", tag, pattern_out, e.pat, $time);
            end
            if (e.chk_tick) begin
                n_compared++;
                assert (tick_o === e.tick) else begin
                    n_mismatched++;
                    $error("[TB] FAIL %s: tick_o observed %b expected %b at %0t", tag, tick_o, e.tick, $time);
                end
            end
        end
    endtask

    task automatic compareVal(input string tag, input int obs, input int expv);
        n_compared++;
        assert (obs === expv) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset for two clocks, then release it on a negative edge with the
    // requested mode already applied.
    task automatic resetTo(input logic [1:0] m);
        applyStimulus(1'b0, 1'b0, m, 1'b0);
        cycles(2);
        applyStimulus(1'b1, 1'b1, m, 1'b0);
    endtask

    // One-hot sweep position j: 01,02,..,80,40,..,02 then repeats every 14 steps.
    function automatic logic [7:0] bounceVal(input int j);
        int         r;
        logic [7:0] one;
        one = 8'h01;
        r   = j % 14;
        return (r < 8) ? (one << r) : (one << (14 - r));
    endfunction

    function automatic logic [7:0] blinkVal(input int j);
        return ((j % 2) == 1) ? 8'hFF : 8'h00;
    endfunction

    initial begin
        int nt;

        // Reset state
        cycles(1);
        pushExp(8'h00, 1'b1, 1'b0);
        checkOutput("reset");

        // Count mode: the pattern after edge k is k/4, and tick_o is high when k%4==3
        resetTo(MODE_COUNT);
        for (int k = 1; k <= 40; k++) begin
            pushExp(8'(k / 4), 1'b1, (k % 4) == 3);
            cycles(1);
            checkOutput("count");
        end
        cycles(1022 - 40);
        pushExp(8'hFF, 1'b1, 1'b1);
        cycles(1);
        checkOutput("count_ff");
        pushExp(8'h00, 1'b1, 1'b0);
        cycles(1);
        checkOutput("count_wrap");

        // Bounce mode from reset. The mode reload happens at edge 3 and the steps are 4 cycles apart.
        resetTo(MODE_BOUNCE);
        cycles(2);
        for (int k = 3; k <= 66; k++) begin
            pushExp(bounceVal((k - 3) / 4), 1'b1, ((k - 3) % 4) == 3);
            cycles(1);
            checkOutput("bounce");
        end
        // Move to pattern 20 on the downward sweep, then assert reset between edges
        cycles(96 - 66);
        pushExp(8'h20, 1'b0, 1'b0);
        checkOutput("bounce_pre_reset");
        #2;
        applyStimulus(1'b0, 1'b1, MODE_COUNT, 1'b0);
        #1;
        pushExp(8'h00, 1'b1, 1'b0);
        checkOutput("async_reset");
        @(negedge clk);
        applyStimulus(1'b1, 1'b1, MODE_COUNT, 1'b0);
        for (int k = 1; k <= 21; k++) begin
            pushExp(8'(k / 4), 1'b1, (k % 4) == 3);
            cycles(1);
            checkOutput("count_restart");
        end

        // Switch to bounce so that the change lands in the tick cycle at pattern 05
        applyStimulus(1'b1, 1'b1, MODE_BOUNCE, 1'b0);
        for (int k = 22; k <= 31; k++) begin
            pushExp((k < 24) ? 8'h05 : ((k < 28) ? 8'h01 : 8'h02), 1'b1,
                    (k == 23) || (k == 27) || (k == 31));
            cycles(1);
            checkOutput("mode_change");
        end

        // Blink mode, with en dropped for 10 cycles while the prescaler count is 1
        resetTo(MODE_BLINK);
        cycles(2);
        for (int k = 3; k <= 12; k++) begin
            pushExp(blinkVal((k - 3) / 4), 1'b1, ((k - 3) % 4) == 3);
            cycles(1);
            checkOutput("blink");
        end
        applyStimulus(1'b1, 1'b0, MODE_BLINK, 1'b0);
        for (int k = 13; k <= 22; k++) begin
            pushExp(8'h00, 1'b1, 1'b0);
            cycles(1);
            checkOutput("blink_frozen");
        end
        applyStimulus(1'b1, 1'b1, MODE_BLINK, 1'b0);
        for (int k = 23; k <= 34; k++) begin
            pushExp(blinkVal((k - 13) / 4), 1'b1, ((k - 13) % 4) == 3);
            cycles(1);
            checkOutput("blink_resume");
        end

        // Manual mode: three clean presses, each held for 10 cycles
        resetTo(MODE_MANUAL);
        cycles(2);
        pushExp(8'h00, 1'b0, 1'b0);
        checkOutput("manual_start");
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, MODE_MANUAL, 1'b1);
            pushExp(8'(i - 1), 1'b0, 1'b0);
            cycles(STEP_LAT - 1);
            checkOutput("manual_before");
            pushExp(8'(i), 1'b0, 1'b0);
            cycles(1);
            checkOutput("manual_step");
            pushExp(8'(i), 1'b0, 1'b0);
            cycles(10 - STEP_LAT);
            applyStimulus(1'b1, 1'b1, MODE_MANUAL, 1'b0);
            cycles(10);
            checkOutput("manual_hold");
        end

        // The prescaler keeps running in manual mode
        nt = 0;
        repeat (8) begin
            @(negedge clk);
            nt += int'(tick_o);
        end
        compareVal("manual_ticks", nt, 2);

        // A 2-cycle glitch increments only when the debouncer is not built
        applyStimulus(1'b1, 1'b1, MODE_MANUAL, 1'b1);
        pushExp(8'h03 + GLITCH_INC, 1'b0, 1'b0);
        cycles(2);
        applyStimulus(1'b1, 1'b1, MODE_MANUAL, 1'b0);
        cycles(15);
        checkOutput("manual_glitch");

        // A press while en=0 is ignored
        applyStimulus(1'b1, 1'b0, MODE_MANUAL, 1'b1);
        pushExp(8'h03 + GLITCH_INC, 1'b0, 1'b0);
        cycles(10);
        applyStimulus(1'b1, 1'b0, MODE_MANUAL, 1'b0);
        cycles(10);
        applyStimulus(1'b1, 1'b1, MODE_MANUAL, 1'b0);
        cycles(5);
        checkOutput("manual_en_block");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
